// File: rtl/zigzag_quantizer.sv
// zigzag_quantizer
//   Takes one 8x8 block of signed DCT coefficients together with a per-position
//   reciprocal table. Each coefficient is quantized by a multiply-shift with
//   round-half-away-from-zero and symmetric saturation. The 64 results are
//   streamed out in JPEG zigzag order. The block is single-buffered: the next
//   block is accepted on the final output handshake, so back-to-back blocks
//   stream with no gap.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   blk_valid  blk_in/recip_in hold a valid block
//   blk_ready  block accepted on the clock edge when blk_valid & blk_ready
//   blk_in     signed coefficients, [row][col]
//   recip_in   unsigned reciprocals round(2^FRAC/q), [row][col]
//   out_valid  out_data/out_index/out_last are valid
//   out_ready  consumer accepts on out_valid & out_ready
//   out_data   signed quantized coefficient
//   out_index  zigzag position 0..63
//   out_last   high together with out_index == 63
module zigzag_quantizer #(
  parameter int COEF_W  = 16,
  parameter int RECIP_W = 16,
  parameter int FRAC    = 12,
  parameter int OUT_W   = 12
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                blk_valid,
  output logic                                blk_ready,
  input  logic [7:0][7:0][COEF_W-1:0]         blk_in,
  input  logic [7:0][7:0][RECIP_W-1:0]        recip_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_W-1:0]             out_data,
  output logic [5:0]                          out_index,
  output logic                                out_last
);

  // Product width: the extra bit keeps |(-2^(COEF_W-1)) * recip| representable.
  localparam int PW = COEF_W + RECIP_W + 1;
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC - 1);
  localparam logic [PW-1:0] QMAX = PW'((2 ** (OUT_W - 1)) - 1);

  // Zigzag position k -> linear index row*8+col.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {IDLE, SCAN} state_t;

  // Multiply-shift quantization with round half away from zero and
  // symmetric clamp to +/-(2^(OUT_W-1)-1).
  function automatic logic signed [OUT_W-1:0] quantize(
    input logic signed [COEF_W-1:0] c,
    input logic [RECIP_W-1:0]       r
  );
    logic signed [PW-1:0] p;
    logic [PW-1:0]        mag;
    logic [PW-1:0]        m;
    p   = PW'(c) * PW'($signed({1'b0, r}));
    mag = p[PW-1] ? PW'(-p) : PW'(p);
    m   = (mag + HALF) >> FRAC;
    if (m > QMAX) m = QMAX;
    return p[PW-1] ? -$signed(m[OUT_W-1:0]) : $signed(m[OUT_W-1:0]);
  endfunction

  state_t                        state_q, state_d;
  logic [5:0]                    idx_q, idx_d;
  logic [7:0][7:0][COEF_W-1:0]   coef_q;
  logic [7:0][7:0][RECIP_W-1:0]  recip_q;
  logic                          cap;
  logic                          accept;
  logic [5:0]                    pos;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cap       = 1'b0;
    // Ready in SCAN only on the final beat's handshake: that is what lets the
    // next block start without a bubble.
    blk_ready = (state_q == IDLE) ||
                ((state_q == SCAN) && (idx_q == 6'd63) && out_ready);
    accept    = blk_valid && blk_ready;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cap     = 1'b1;
          idx_d   = 6'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (idx_q == 6'd63) begin
            idx_d = 6'd0;
            if (accept) cap = 1'b1;
            else        state_d = IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      coef_q  <= '0;
      recip_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cap) begin
        coef_q  <= blk_in;
        recip_q <= recip_in;
      end
    end
  end

  // Outputs come straight from registered state, so they hold under backpressure.
  always_comb begin
    pos       = ZZ[idx_q];
    out_valid = (state_q == SCAN);
    out_index = idx_q;
    out_last  = (state_q == SCAN) && (idx_q == 6'd63);
    out_data  = '0;
    if (state_q == SCAN)
      out_data = quantize($signed(coef_q[pos[5:3]][pos[2:0]]), recip_q[pos[5:3]][pos[2:0]]);
  end

endmodule

// File: tb/tb_zigzag_quantizer.sv
module tb_zigzag_quantizer;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      blk_valid;
  logic                      blk_ready;
  logic [7:0][7:0][15:0]     blk_in;
  logic [7:0][7:0][15:0]     recip_in;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [11:0]        out_data;
  logic [5:0]                out_index;
  logic                      out_last;

  int checks = 0;
  int errors = 0;

  int zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int qexp [64];

  always #5 clk = ~clk;

  zigzag_quantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_in    (blk_in),
    .recip_in  (recip_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base, input int sgn, input logic [15:0] rc);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        blk_in[r][c]   = 16'(sgn * (8 * r + c) + base);
        recip_in[r][c] = rc;
      end
  endtask

  initial begin
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    out_ready = 1'b1;
    blk_in    = '0;
    recip_in  = '0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_blk_ready", blk_ready, 1);
    chk("reset_out_index", out_index, 0);
    chk("reset_out_last", out_last, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Ordering: coefficient value equals its linear position, unity reciprocal.
    fill(0, 1, 16'd4096);
    blk_valid = 1'b1;
    #1;
    chk("order_blk_ready_idle", blk_ready, 1);
    step();
    blk_valid = 1'b0;
    chk("order_first_valid", out_valid, 1);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("order_index_%0d", k), out_index, k);
      chk($sformatf("order_data_%0d", k), out_data, zz[k]);
      chk($sformatf("order_last_%0d", k), out_last, (k == 63) ? 1 : 0);
      chk($sformatf("order_blk_ready_%0d", k), blk_ready, (k == 63) ? 1 : 0);
      step();
    end
    chk("order_done_valid", out_valid, 0);
    chk("order_done_blk_ready", blk_ready, 1);

    // Rounding, recip=0, saturation, then a 5-cycle stall at index 10.
    fill(0, 0, 16'd4096);
    for (int k = 0; k < 64; k++) qexp[k] = 0;
    blk_in[0][0] = 16'd5;                      recip_in[0][0] = 16'd2048; qexp[0]  = 3;
    blk_in[0][1] = 16'(-5);                    recip_in[0][1] = 16'd2048; qexp[1]  = -3;
    blk_in[1][0] = 16'd4;                      recip_in[1][0] = 16'd2048; qexp[2]  = 2;
    blk_in[2][0] = 16'(-10);                   recip_in[2][0] = 16'd2048; qexp[3]  = -5;
    blk_in[1][1] = 16'd1;                      recip_in[1][1] = 16'd2048; qexp[4]  = 1;
    blk_in[0][2] = 16'd0;                      recip_in[0][2] = 16'd2048; qexp[5]  = 0;
    blk_in[0][3] = 16'd1000;                   recip_in[0][3] = 16'd0;    qexp[6]  = 0;
    blk_in[1][2] = 16'd32767;                  recip_in[1][2] = 16'd65535; qexp[7] = 2047;
    blk_in[2][1] = 16'h8000;                   recip_in[2][1] = 16'd65535; qexp[8] = -2047;
    blk_in[3][0] = 16'(-1);                    recip_in[3][0] = 16'd2048; qexp[9]  = -1;
    blk_in[4][0] = 16'd7;                      qexp[10] = 7;
    blk_in[3][1] = 16'(-3);                    qexp[11] = -3;
    blk_valid = 1'b1;
    step();
    blk_valid = 1'b0;
    blk_in    = '0;
    recip_in  = '0;
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("quant_valid_%0d", k), out_valid, 1);
      chk($sformatf("quant_index_%0d", k), out_index, k);
      chk($sformatf("quant_data_%0d", k), out_data, qexp[k]);
      chk($sformatf("quant_blk_ready_%0d", k), blk_ready, (k == 63) ? 1 : 0);
      if (k == 10) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          chk($sformatf("stall_valid_%0d", s), out_valid, 1);
          chk($sformatf("stall_index_%0d", s), out_index, 10);
          chk($sformatf("stall_data_%0d", s), out_data, 7);
          chk($sformatf("stall_blk_ready_%0d", s), blk_ready, 0);
        end
        out_ready = 1'b1;
        #1;
      end
      step();
    end
    chk("quant_done_valid", out_valid, 0);

    // Back-to-back: blk_valid held, 128 beats with no gap, third block reset mid-scan.
    fill(0, 1, 16'd4096);
    blk_valid = 1'b1;
    step();
    fill(64, 1, 16'd4096);
    for (int b = 0; b < 128; b++) begin
      chk($sformatf("b2b_valid_%0d", b), out_valid, 1);
      chk($sformatf("b2b_index_%0d", b), out_index, b % 64);
      chk($sformatf("b2b_data_%0d", b), out_data, zz[b % 64] + ((b >= 64) ? 64 : 0));
      chk($sformatf("b2b_blk_ready_%0d", b), blk_ready, ((b % 64) == 63) ? 1 : 0);
      step();
      if (b == 63) fill(0, -1, 16'd4096);
    end
    for (int k = 0; k <= 30; k++) begin
      chk($sformatf("third_valid_%0d", k), out_valid, 1);
      chk($sformatf("third_data_%0d", k), out_data, -zz[k]);
      if (k < 30) step();
    end
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_out_data", out_data, 0);
    chk("midreset_blk_ready", blk_ready, 1);
    chk("midreset_out_index", out_index, 0);
    step();
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) begin
      step();
      chk($sformatf("post_reset_valid_%0d", s), out_valid, 0);
      chk($sformatf("post_reset_blk_ready_%0d", s), blk_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
